// File: rtl/timer_ctrl.sv
// Countdown timer controller: set minutes/seconds, count down on a 1 Hz enable, pause, done.
// Optional feature: define TIMER_PRESET_RELOAD_EN to reload the started value when returning to SET.
module timer_ctrl #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       pause_resume,
    input  logic       set_min,
    input  logic       set_sec,
    input  logic       tick_1hz,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] state,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_COUNT = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [5:0] MIN_TOP = 6'(MIN_MAX);
    localparam logic [5:0] SEC_TOP = 6'd59;

    state_e     state_q, state_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic [5:0] reload_min, reload_sec;

`ifdef TIMER_PRESET_RELOAD_EN
    logic [5:0] preset_min_q, preset_min_d;
    logic [5:0] preset_sec_q, preset_sec_d;

    assign reload_min = preset_min_q;
    assign reload_sec = preset_sec_q;
`else
    assign reload_min = 6'd0;
    assign reload_sec = 6'd0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
`ifdef TIMER_PRESET_RELOAD_EN
        preset_min_d = preset_min_q;
        preset_sec_d = preset_sec_q;
`endif
        case (state_q)
            ST_SET: begin
                if (start_stop) begin
                    if ((min_q != 6'd0) || (sec_q != 6'd0)) begin
                        state_d = ST_COUNT;
`ifdef TIMER_PRESET_RELOAD_EN
                        preset_min_d = min_q;
                        preset_sec_d = sec_q;
`endif
                    end
                end else begin
                    if (set_min) min_d = (min_q == MIN_TOP) ? 6'd0 : min_q + 6'd1;
                    if (set_sec) sec_d = (sec_q == SEC_TOP) ? 6'd0 : sec_q + 6'd1;
                end
            end
            ST_COUNT: begin
                if (start_stop) begin
                    state_d = ST_SET;
                    min_d   = reload_min;
                    sec_d   = reload_sec;
                end else if (pause_resume) begin
                    state_d = ST_PAUSE;
                end else if (tick_1hz) begin
                    // COUNT never holds 00:00, so the minute borrow cannot underflow.
                    if (sec_q != 6'd0) begin
                        sec_d = sec_q - 6'd1;
                    end else begin
                        min_d = min_q - 6'd1;
                        sec_d = SEC_TOP;
                    end
                    if ((min_d == 6'd0) && (sec_d == 6'd0)) state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (start_stop) begin
                    state_d = ST_SET;
                    min_d   = reload_min;
                    sec_d   = reload_sec;
                end else if (pause_resume) begin
                    state_d = ST_COUNT;
                end
            end
            ST_DONE: begin
                if (start_stop) begin
                    state_d = ST_SET;
                    min_d   = reload_min;
                    sec_d   = reload_sec;
                end
            end
            default: state_d = ST_SET;
        endcase

        running_d = (state_d == ST_COUNT);
        done_d    = (state_d == ST_DONE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SET;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

`ifdef TIMER_PRESET_RELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset_min_q <= 6'd0;
            preset_sec_q <= 6'd0;
        end else begin
            preset_min_q <= preset_min_d;
            preset_sec_q <= preset_sec_d;
        end
    end
`endif

    assign min     = min_q;
    assign sec     = sec_q;
    assign state   = state_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for countdown-to-done, pause, wrap and async reset.
module tb_timer_ctrl;

    localparam int MIN_MAX = 59;

`ifdef TIMER_PRESET_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start_stop, pause_resume, set_min, set_sec, tick_1hz;
    logic [5:0] min, sec;
    logic [1:0] state;
    logic       running, done;

    int errors = 0;
    int checks = 0;

    timer_ctrl #(.MIN_MAX(MIN_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_stop   (start_stop),
        .pause_resume (pause_resume),
        .set_min      (set_min),
        .set_sec      (set_sec),
        .tick_1hz     (tick_1hz),
        .min          (min),
        .sec          (sec),
        .state        (state),
        .running      (running),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ss, pr, sm, sc, tk;
        logic [1:0] st;
        logic [5:0] mn, se;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input int st, input int mn, input int se);
        check({name, ".state"}, int'(state), st);
        check({name, ".min"}, int'(min), mn);
        check({name, ".sec"}, int'(sec), se);
        check({name, ".running"}, int'(running), (st == 1) ? 1 : 0);
        check({name, ".done"}, int'(done), (st == 3) ? 1 : 0);
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled on the next one.
    task automatic step(input logic ss, input logic pr, input logic sm, input logic sc, input logic tk);
        start_stop   = ss;
        pause_resume = pr;
        set_min      = sm;
        set_sec      = sc;
        tick_1hz     = tk;
        @(posedge clk);
        #1;
        start_stop   = 1'b0;
        pause_resume = 1'b0;
        set_min      = 1'b0;
        set_sec      = 1'b0;
        tick_1hz     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input logic ss, input logic pr, input logic sm, input logic sc,
                       input logic tk, input int st, input int mn, input int se);
        vecs[nvec] = '{n, ss, pr, sm, sc, tk, 2'(st), 6'(mn), 6'(se)};
        nvec++;
    endtask

    initial begin
        start_stop = 0; pause_resume = 0; set_min = 0; set_sec = 0; tick_1hz = 0;
        rst_n = 1'b1;

        //      name               ss pr sm sc tk  st mn se
        add("ss_at_zero",         1, 0, 0, 0, 0, 0, 0, 0);
        add("tick_in_set",        0, 0, 0, 0, 1, 0, 0, 0);
        add("pr_in_set",          0, 1, 0, 0, 0, 0, 0, 0);
        add("min1",               0, 0, 1, 0, 0, 0, 1, 0);
        add("min2",               0, 0, 1, 0, 0, 0, 2, 0);
        add("min3",               0, 0, 1, 0, 0, 0, 3, 0);
        add("sec1",               0, 0, 0, 1, 0, 0, 3, 1);
        add("sec2",               0, 0, 0, 1, 0, 0, 3, 2);
        add("sec3",               0, 0, 0, 1, 0, 0, 3, 3);
        add("sec4",               0, 0, 0, 1, 0, 0, 3, 4);
        add("sec5",               0, 0, 0, 1, 0, 0, 3, 5);
        add("start",              1, 0, 0, 0, 0, 1, 3, 5);
        add("tick1",              0, 0, 0, 0, 1, 1, 3, 4);
        add("setmin_count",       0, 0, 1, 0, 0, 1, 3, 4);
        add("setsec_count",       0, 0, 0, 1, 0, 1, 3, 4);
        add("pause_beats_tick",   0, 1, 0, 0, 1, 2, 3, 4);
        add("tick_paused",        0, 0, 0, 0, 1, 2, 3, 4);
        add("setmin_paused",      0, 0, 1, 0, 0, 2, 3, 4);
        add("resume",             0, 1, 0, 0, 0, 1, 3, 4);
        add("tick2",              0, 0, 0, 0, 1, 1, 3, 3);
        add("stop_beats_all",     1, 1, 1, 0, 1, 0, RELOAD ? 3 : 0, RELOAD ? 5 : 0);
        add("both_set",           0, 0, 1, 1, 0, 0, RELOAD ? 4 : 1, RELOAD ? 6 : 1);

        rst_n = 1'b0;
        #3;
        check_out("reset", 0, 0, 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].ss, vecs[i].pr, vecs[i].sm, vecs[i].sc, vecs[i].tk);
            check_out(vecs[i].name, vecs[i].st, vecs[i].mn, vecs[i].se);
        end

        // Countdown into DONE, then DONE ignores everything but start_stop.
        do_reset();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check_out("done_t1", 1, 0, 1);
        step(0, 0, 0, 0, 1);
        check_out("done_t2", 3, 0, 0);
        step(0, 0, 0, 0, 1);
        check_out("done_t3", 3, 0, 0);
        step(0, 1, 1, 1, 0);
        check_out("done_ignore", 3, 0, 0);
        step(1, 0, 0, 0, 0);
        check_out("done_stop", 0, 0, RELOAD ? 2 : 0);

        // Borrow across the minute, pause holds, then stop with a same-cycle tick.
        do_reset();
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check_out("p_start", 1, 1, 0);
        step(0, 0, 0, 0, 1);
        check_out("p_borrow", 1, 0, 59);
        step(0, 1, 0, 0, 0);
        check_out("p_pause", 2, 0, 59);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        check_out("p_hold", 2, 0, 59);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check_out("p_resume", 1, 0, 58);
        for (int i = 0; i < 48; i++) step(0, 0, 0, 0, 1);
        check_out("p_at10", 1, 0, 10);
        step(1, 0, 0, 0, 1);
        check_out("p_stop_tick", 0, RELOAD ? 1 : 0, 0);

        // Field wrap in SET.
        do_reset();
        for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 0);
        check_out("sec_top", 0, 0, 59);
        step(0, 0, 0, 1, 0);
        check_out("sec_wrap", 0, 0, 0);
        for (int i = 0; i < MIN_MAX; i++) step(0, 0, 1, 0, 0);
        check_out("min_top", 0, MIN_MAX, 0);
        step(0, 0, 1, 0, 0);
        check_out("min_wrap", 0, 0, 0);

        // Asynchronous reset between edges while counting at 02:30.
        do_reset();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        check_out("r_count", 1, 2, 30);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("r_async", 0, 0, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        check_out("r_after", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
